// File: rtl/alarm_pkg.sv
// alarm_pkg: shared state type, digit width and channel-id width helper for alarm_ctrl.
package alarm_pkg;
  typedef enum logic [1:0] {IDLE, RINGING, SNOOZE} state_t;
  localparam int BCD_W = 4;
  function automatic int idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/alarm_bank.sv
// alarm_bank: alarm register file, per-channel compare, match edge detect and lowest-index trigger encoder.
module alarm_bank
  import alarm_pkg::*;
#(
  parameter int W          = 16,
  parameter int NUM_ALARMS = 2,
  parameter int IDW        = idw(NUM_ALARMS)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [W-1:0]                     current_time,
  input  logic                             alarm_wr,
  input  logic [IDW-1:0]                   alarm_sel,
  input  logic [W-1:0]                     alarm_wdata,
  input  logic [NUM_ALARMS-1:0]            alarm_en,
  output logic [NUM_ALARMS-1:0][W-1:0]     alarms,
  output logic                             trigger,
  output logic [IDW-1:0]                   trig_id
);
  logic [NUM_ALARMS-1:0][W-1:0] alarm_q, alarm_d;
  logic [NUM_ALARMS-1:0]        match, match_q, edge_v;

  assign alarms  = alarm_q;
  assign trigger = |edge_v;

  // Out-of-range selects match no channel, so such writes fall away.
  always_comb begin
    alarm_d = alarm_q;
    match   = '0;
    trig_id = '0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      alarm_d[i] = (alarm_wr && int'(alarm_sel) == i) ? alarm_wdata : alarm_q[i];
      match[i]   = alarm_en[i] && (alarm_q[i] == current_time);
    end
    edge_v = match & ~match_q;
    for (int i = NUM_ALARMS - 1; i >= 0; i--)
      trig_id = edge_v[i] ? IDW'(i) : trig_id;
  end

  // match_q resets to all ones so an equality present at reset release cannot ring.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      alarm_q <= '0;
      match_q <= '1;
    end else begin
      alarm_q <= alarm_d;
      match_q <= match;
    end
endmodule

// File: rtl/alarm_ctrl.sv
// alarm_ctrl: multi-channel alarm controller with snooze, ring timeout and display mux.
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int NUM_ALARMS   = 2,
  parameter int SNOOZE_TICKS = 5,
  parameter int RING_TICKS   = 10,
  parameter int W            = BCD_W * DIGITS,
  parameter int IDW          = idw(NUM_ALARMS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick,
  input  logic [W-1:0]          current_time,
  input  logic                  alarm_wr,
  input  logic [IDW-1:0]        alarm_sel,
  input  logic [W-1:0]          alarm_wdata,
  input  logic [NUM_ALARMS-1:0] alarm_en,
  input  logic                  show_a,
  input  logic [IDW-1:0]        show_sel,
  input  logic                  snooze,
  input  logic                  alarm_off,
  output logic [W-1:0]          display_time,
  output logic                  sound_alarm,
  output logic                  snoozing,
  output logic [IDW-1:0]        ring_id
);
  localparam int RCW = $clog2(RING_TICKS + 1);
  localparam int SCW = $clog2(SNOOZE_TICKS + 1);
  localparam logic [RCW-1:0] RING_LAST = RCW'(RING_TICKS - 1);
  localparam logic [SCW-1:0] SNZ_INIT  = SCW'(SNOOZE_TICKS);

  logic [NUM_ALARMS-1:0][W-1:0] alarms;
  logic                         trigger;
  logic [IDW-1:0]               trig_id;
  state_t                       state_q, state_d;
  logic [IDW-1:0]               ring_id_q, ring_id_d;
  logic [RCW-1:0]               ring_cnt_q, ring_cnt_d;
  logic [SCW-1:0]               snz_cnt_q, snz_cnt_d;
  logic [W-1:0]                 display_q, display_d;

  alarm_bank #(.W(W), .NUM_ALARMS(NUM_ALARMS), .IDW(IDW)) u_bank (
    .clk(clk), .rst_n(rst_n), .current_time(current_time), .alarm_wr(alarm_wr),
    .alarm_sel(alarm_sel), .alarm_wdata(alarm_wdata), .alarm_en(alarm_en),
    .alarms(alarms), .trigger(trigger), .trig_id(trig_id)
  );

  assign display_time = display_q;
  assign sound_alarm  = state_q == RINGING;
  assign snoozing     = state_q == SNOOZE;
  assign ring_id      = ring_id_q;

  // Priority throughout: alarm_off > snooze > trigger > tick.
  always_comb begin
    state_d    = state_q;
    ring_id_d  = ring_id_q;
    ring_cnt_d = ring_cnt_q;
    snz_cnt_d  = snz_cnt_q;
    display_d  = show_a ? ((int'(show_sel) < NUM_ALARMS) ? alarms[show_sel] : '0) : current_time;
    case (state_q)
      IDLE:
        if (!alarm_off && !snooze && trigger) begin
          state_d    = RINGING;
          ring_id_d  = trig_id;
          ring_cnt_d = '0;
        end
      RINGING:
        if (alarm_off) state_d = IDLE;
        else if (snooze) begin
          state_d   = SNOOZE;
          snz_cnt_d = SNZ_INIT;
        end else if (tick) begin
          state_d    = (ring_cnt_q == RING_LAST) ? IDLE : RINGING;
          ring_cnt_d = (ring_cnt_q == RING_LAST) ? '0 : ring_cnt_q + 1'b1;
        end
      SNOOZE:
        if (alarm_off) state_d = IDLE;
        else if (trigger) begin
          state_d    = RINGING;
          ring_id_d  = trig_id;
          ring_cnt_d = '0;
        end else if (tick) begin
          state_d    = (snz_cnt_q == SCW'(1)) ? RINGING : SNOOZE;
          snz_cnt_d  = snz_cnt_q - 1'b1;
          ring_cnt_d = '0;
        end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= IDLE;
      ring_id_q  <= '0;
      ring_cnt_q <= '0;
      snz_cnt_q  <= '0;
      display_q  <= '0;
    end else begin
      state_q    <= state_d;
      ring_id_q  <= ring_id_d;
      ring_cnt_q <= ring_cnt_d;
      snz_cnt_q  <= snz_cnt_d;
      display_q  <= display_d;
    end
endmodule

// File: tb/tb_alarm_ctrl.sv
// tb_alarm_ctrl: directed scenarios plus randomized traffic checked against a remaining-ticks reference model.
module tb_alarm_ctrl;
  localparam int NA  = 2;
  localparam int SNZ = 5;
  localparam int RT  = 10;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        tick = 0;
  logic [15:0] current_time = 0;
  logic        alarm_wr = 0;
  logic [0:0]  alarm_sel = 0;
  logic [15:0] alarm_wdata = 0;
  logic [1:0]  alarm_en = 0;
  logic        show_a = 0;
  logic [0:0]  show_sel = 0;
  logic        snooze = 0;
  logic        alarm_off = 0;
  logic [15:0] display_time;
  logic        sound_alarm, snoozing;
  logic [0:0]  ring_id;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_alarm [NA];
  logic [NA-1:0] m_prev;
  bit          m_ring, m_snz;
  int          ring_left, snz_left, m_id;
  logic [15:0] m_disp;

  alarm_ctrl #(.DIGITS(4), .NUM_ALARMS(NA), .SNOOZE_TICKS(SNZ), .RING_TICKS(RT)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .current_time(current_time),
    .alarm_wr(alarm_wr), .alarm_sel(alarm_sel), .alarm_wdata(alarm_wdata),
    .alarm_en(alarm_en), .show_a(show_a), .show_sel(show_sel), .snooze(snooze),
    .alarm_off(alarm_off), .display_time(display_time), .sound_alarm(sound_alarm),
    .snoozing(snoozing), .ring_id(ring_id)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < NA; i++) m_alarm[i] = 0;
    m_prev = '1; m_ring = 0; m_snz = 0; ring_left = 0; snz_left = 0; m_id = 0; m_disp = 0;
  endtask

  // Model counts remaining ticks downward; the clock edge applies it to the sampled inputs.
  task automatic model_step();
    logic [NA-1:0] mt;
    int first;
    if (!rst_n) begin model_reset(); return; end
    first = -1;
    for (int i = 0; i < NA; i++) mt[i] = alarm_en[i] && (m_alarm[i] == current_time);
    for (int i = NA - 1; i >= 0; i--) if (mt[i] && !m_prev[i]) first = i;
    m_disp = show_a ? ((int'(show_sel) < NA) ? m_alarm[show_sel] : 16'h0) : current_time;
    if (m_ring) begin
      if (alarm_off) m_ring = 0;
      else if (snooze) begin m_ring = 0; m_snz = 1; snz_left = SNZ; end
      else if (tick) begin ring_left--; if (ring_left == 0) m_ring = 0; end
    end else if (m_snz) begin
      if (alarm_off) m_snz = 0;
      else if (first >= 0) begin m_snz = 0; m_ring = 1; ring_left = RT; m_id = first; end
      else if (tick) begin
        snz_left--;
        if (snz_left == 0) begin m_snz = 0; m_ring = 1; ring_left = RT; end
      end
    end else if (!alarm_off && !snooze && first >= 0) begin
      m_ring = 1; ring_left = RT; m_id = first;
    end
    if (alarm_wr && int'(alarm_sel) < NA) m_alarm[alarm_sel] = alarm_wdata;
    m_prev = mt;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_alarm(input int sel, input logic [15:0] t);
    alarm_wr = 1; alarm_sel = sel[0:0]; alarm_wdata = t;
    cycle();
    alarm_wr = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; current_time = 16'h0000; alarm_en = 2'b01;
    model_reset();
    #3;
    checks++;
    if (sound_alarm !== 0 || snoozing !== 0 || display_time !== 0 || ring_id !== 0) begin
      errors++; $display("FAIL reset_outputs: sound=%b snz=%b disp=%h id=%0d, want all 0", sound_alarm, snoozing, display_time, ring_id);
    end
    @(posedge clk); #1;
    rst_n = 1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      checks++;
      if (sound_alarm !== 0) begin errors++; $display("FAIL reset_no_spurious: sound=%b want 0", sound_alarm); end
    end
    current_time = 16'h0001; cycle();
    current_time = 16'h0000; cycle();
    checks++;
    if (sound_alarm !== 1 || ring_id !== 0) begin
      errors++; $display("FAIL reset_return_ring: sound=%b id=%0d want 1/0", sound_alarm, ring_id);
    end
    alarm_off = 1; cycle(); alarm_off = 0;
  endtask

  task automatic test_single();
    alarm_en = 2'b10;
    write_alarm(1, 16'h0730);
    current_time = 16'h0730; cycle();
    checks++;
    if (sound_alarm !== 1 || ring_id !== 1) begin
      errors++; $display("FAIL single_ring: sound=%b id=%0d want 1/1", sound_alarm, ring_id);
    end
    alarm_off = 1; cycle(); alarm_off = 0;
    checks++;
    if (sound_alarm !== 0) begin errors++; $display("FAIL single_off: sound=%b want 0", sound_alarm); end
    for (int k = 0; k < 4; k++) cycle();
    checks++;
    if (sound_alarm !== 0) begin errors++; $display("FAIL single_held_no_rering: sound=%b want 0", sound_alarm); end
  endtask

  task automatic test_priority();
    write_alarm(0, 16'h0600);
    write_alarm(1, 16'h0600);
    alarm_en = 2'b11;
    current_time = 16'h0600; cycle();
    checks++;
    if (sound_alarm !== 1 || ring_id !== 0) begin
      errors++; $display("FAIL priority_lowest: sound=%b id=%0d want 1/0", sound_alarm, ring_id);
    end
    alarm_off = 1; cycle(); alarm_off = 0;
  endtask

  task automatic test_snooze_timeout();
    current_time = 16'h0000; cycle();
    current_time = 16'h0600; cycle();
    snooze = 1; tick = 1; cycle(); snooze = 0; tick = 0;
    checks++;
    if (snoozing !== 1 || sound_alarm !== 0) begin
      errors++; $display("FAIL snooze_enter: snz=%b sound=%b want 1/0", snoozing, sound_alarm);
    end
    for (int k = 1; k <= SNZ; k++) begin
      tick = 1; cycle(); tick = 0; cycle();
      checks++;
      if (sound_alarm !== (k == SNZ) || snoozing !== (k != SNZ)) begin
        errors++; $display("FAIL snooze_tick%0d: sound=%b snz=%b", k, sound_alarm, snoozing);
      end
    end
    for (int k = 1; k <= RT; k++) begin
      tick = 1; cycle(); tick = 0;
      checks++;
      if (sound_alarm !== (k != RT)) begin
        errors++; $display("FAIL ring_tick%0d: sound=%b want %0d", k, sound_alarm, k != RT);
      end
    end
  endtask

  task automatic test_preempt_display();
    write_alarm(1, 16'h0601);
    current_time = 16'h0000; cycle();
    current_time = 16'h0600; cycle();
    snooze = 1; cycle(); snooze = 0;
    current_time = 16'h0601; cycle();
    checks++;
    if (sound_alarm !== 1 || snoozing !== 0 || ring_id !== 1) begin
      errors++; $display("FAIL preempt: sound=%b snz=%b id=%0d want 1/0/1", sound_alarm, snoozing, ring_id);
    end
    show_a = 1; show_sel = 1; cycle();
    checks++;
    if (display_time !== 16'h0601) begin errors++; $display("FAIL display_a1: disp=%h want 0601", display_time); end
    show_sel = 0; cycle();
    checks++;
    if (display_time !== 16'h0600) begin errors++; $display("FAIL display_a0: disp=%h want 0600", display_time); end
    show_a = 0; current_time = 16'h1234; cycle();
    checks++;
    if (display_time !== 16'h1234) begin errors++; $display("FAIL display_time: disp=%h want 1234", display_time); end
    alarm_off = 1; cycle(); alarm_off = 0;
  endtask

  task automatic test_async_reset();
    current_time = 16'h0000; cycle();
    current_time = 16'h0600; cycle();
    #2 rst_n = 0;
    model_reset();
    #1;
    checks++;
    if (sound_alarm !== 0 || snoozing !== 0 || ring_id !== 0 || display_time !== 0) begin
      errors++; $display("FAIL async_reset: sound=%b snz=%b id=%0d disp=%h want 0", sound_alarm, snoozing, ring_id, display_time);
    end
    cycle();
    rst_n = 1;
    show_a = 1; show_sel = 1; cycle();
    checks++;
    if (display_time !== 0 || sound_alarm !== 0) begin
      errors++; $display("FAIL reset_regs_cleared: disp=%h sound=%b want 0", display_time, sound_alarm);
    end
    show_a = 0;
  endtask

  task automatic test_random();
    logic [15:0] times [4];
    times[0] = 16'h0000; times[1] = 16'h0730; times[2] = 16'h0600; times[3] = 16'h1234;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 4) == 0) current_time = times[$urandom_range(0, 3)];
      alarm_wr = ($urandom_range(0, 19) == 0);
      alarm_sel = 1'($urandom_range(0, 1));
      alarm_wdata = times[$urandom_range(0, 3)];
      if ($urandom_range(0, 19) == 0) alarm_en = 2'($urandom_range(0, 3));
      show_a = 1'($urandom_range(0, 1));
      show_sel = 1'($urandom_range(0, 1));
      tick = ($urandom_range(0, 3) == 0);
      snooze = ($urandom_range(0, 24) == 0);
      alarm_off = ($urandom_range(0, 49) == 0);
      cycle();
      checks++;
      if (sound_alarm !== m_ring || snoozing !== m_snz || ring_id !== m_id[0:0] || display_time !== m_disp) begin
        errors++;
        $display("FAIL random_cycle%0d: sound=%b/%b snz=%b/%b id=%0d/%0d disp=%h/%h (got/want)",
                 n, sound_alarm, m_ring, snoozing, m_snz, ring_id, m_id, display_time, m_disp);
      end
    end
    alarm_wr = 0; tick = 0; snooze = 0; alarm_off = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_snooze_timeout();
    test_preempt_display();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
